// File: rtl/fetch_controller.sv
// Instruction fetch controller: sequences the fetch PC and instruction memory
// requests, holds a returned word while decode is stalled, and squashes an
// in-flight request when execute resolves a taken branch/jump.
module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_d,
  input  logic        redirect_e,
  input  logic [31:0] redirect_pc_e,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic        fetch_en,
  output logic [31:0] pc_next_f,
  output logic [31:0] instr_f,
  output logic        flush_d
);

  typedef enum logic [1:0] {
    StBoot,
    StReq,
    StHold,
    StKill
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] instr_q, instr_d;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
      tgt_q   <= 32'h0;
      instr_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      instr_q <= instr_d;
    end
  end

  // Next-state and datapath update; redirect outranks stall and ready.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    instr_d = instr_q;
    unique case (state_q)
      StBoot: begin
        state_d = StReq;
      end
      StReq: begin
        if (redirect_e) begin
          if (imem_ready) begin
            pc_d    = redirect_pc_e;
            state_d = StReq;
          end else begin
            // Request still in flight: remember target until memory answers.
            tgt_d   = redirect_pc_e;
            state_d = StKill;
          end
        end else if (imem_ready) begin
          instr_d = imem_rdata;
          if (stall_d) begin
            state_d = StHold;
          end else begin
            pc_d    = pc_q + PC_STEP;
            state_d = StReq;
          end
        end
      end
      StHold: begin
        if (redirect_e) begin
          pc_d    = redirect_pc_e;
          state_d = StReq;
        end else if (!stall_d) begin
          pc_d    = pc_q + PC_STEP;
          state_d = StReq;
        end
      end
      StKill: begin
        if (redirect_e) begin
          tgt_d = redirect_pc_e;
        end
        if (imem_ready) begin
          pc_d    = redirect_e ? redirect_pc_e : tgt_q;
          state_d = StReq;
        end
      end
      default: begin
        state_d = StBoot;
      end
    endcase
  end

  // Moore/Mealy outputs derived from state and current inputs.
  always_comb begin
    imem_req  = (state_q == StReq) || (state_q == StKill);
    imem_addr = pc_q;
    pc_next_f = pc_q;
    instr_f   = instr_q;
    flush_d   = redirect_e && (state_q != StBoot);
    fetch_en  = 1'b0;
    if (!redirect_e && !stall_d) begin
      if (state_q == StReq) begin
        fetch_en = imem_ready;
      end else if (state_q == StHold) begin
        fetch_en = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: cycle vectors are queued with their
// expected outputs and compared at the falling edge of the same cycle.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_d;
  logic        redirect_e;
  logic [31:0] redirect_pc_e;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        fetch_en;
  logic [31:0] pc_next_f;
  logic [31:0] instr_f;
  logic        flush_d;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_controller dut (
    .clk          (clk),
    .reset        (reset),
    .stall_d      (stall_d),
    .redirect_e   (redirect_e),
    .redirect_pc_e(redirect_pc_e),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .fetch_en     (fetch_en),
    .pc_next_f    (pc_next_f),
    .instr_f      (instr_f),
    .flush_d      (flush_d)
  );

  typedef struct {
    logic        rst;
    logic        stl;
    logic        rdr;
    logic [31:0] rpc;
    logic        rdy;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_fen;
    logic        e_flush;
    logic [31:0] e_instr;
  } vec_t;

  typedef struct {
    int          idx;
    logic        req;
    logic [31:0] addr;
    logic        fen;
    logic        flush;
    logic [31:0] instr;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t mk(logic rst, logic stl, logic rdr, logic [31:0] rpc, logic rdy,
                              logic [31:0] rdata, logic e_req, logic [31:0] e_addr,
                              logic e_fen, logic e_flush, logic [31:0] e_instr);
    vec_t v;
    v.rst = rst; v.stl = stl; v.rdr = rdr; v.rpc = rpc; v.rdy = rdy; v.rdata = rdata;
    v.e_req = e_req; v.e_addr = e_addr; v.e_fen = e_fen; v.e_flush = e_flush;
    v.e_instr = e_instr;
    return v;
  endfunction

  // Drive one cycle, queue its expectation, compare at negedge, advance past posedge.
  task automatic apply(input int idx, input vec_t v);
    exp_t e;
    exp_t got;
    reset         = v.rst;
    stall_d       = v.stl;
    redirect_e    = v.rdr;
    redirect_pc_e = v.rpc;
    imem_ready    = v.rdy;
    imem_rdata    = v.rdata;
    e.idx = idx; e.req = v.e_req; e.addr = v.e_addr; e.fen = v.e_fen;
    e.flush = v.e_flush; e.instr = v.e_instr;
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    checks++;
    if (imem_req !== got.req || imem_addr !== got.addr || pc_next_f !== got.addr ||
        fetch_en !== got.fen || flush_d !== got.flush || instr_f !== got.instr) begin
      failures++;
      $display("FAIL vec%0d: got req=%b addr=%h pcn=%h fen=%b flush=%b instr=%h, want req=%b addr=%h pcn=%h fen=%b flush=%b instr=%h",
               got.idx, imem_req, imem_addr, pc_next_f, fetch_en, flush_d, instr_f,
               got.req, got.addr, got.addr, got.fen, got.flush, got.instr);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] prev;
    // rst stl rdr rpc  rdy rdata        | req addr fen flush instr
    vecs.push_back(mk(1, 0, 1, 32'h55, 1, 32'h0,         0, 32'h0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,  1, 32'hD0,        0, 32'h0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,  1, 32'h1000_0000, 1, 32'h0, 1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,  1, 32'h1000_0004, 1, 32'h4, 1, 0, 32'h1000_0000));
    vecs.push_back(mk(0, 0, 0, 32'h0,  0, 32'hEEEE_0000, 1, 32'h8, 0, 0, 32'h1000_0004));
    vecs.push_back(mk(0, 1, 0, 32'h0,  0, 32'hEEEE_0001, 1, 32'h8, 0, 0, 32'h1000_0004));
    vecs.push_back(mk(0, 0, 0, 32'h0,  0, 32'hEEEE_0002, 1, 32'h8, 0, 0, 32'h1000_0004));
    vecs.push_back(mk(0, 0, 0, 32'h0,  1, 32'h1000_0008, 1, 32'h8, 1, 0, 32'h1000_0004));
    vecs.push_back(mk(0, 1, 0, 32'h0,  1, 32'h1000_000C, 1, 32'hC, 0, 0, 32'h1000_0008));
    vecs.push_back(mk(0, 1, 0, 32'h0,  1, 32'hDEAD_BEEF, 0, 32'hC, 0, 0, 32'h1000_000C));
    vecs.push_back(mk(0, 0, 0, 32'h0,  1, 32'hDEAD_BEEF, 0, 32'hC, 1, 0, 32'h1000_000C));
    vecs.push_back(mk(0, 0, 1, 32'h100, 0, 32'h0,        1, 32'h10, 0, 1, 32'h1000_000C));
    vecs.push_back(mk(0, 0, 0, 32'h0,  0, 32'h0,         1, 32'h10, 0, 0, 32'h1000_000C));
    vecs.push_back(mk(0, 0, 1, 32'h200, 0, 32'h0,        1, 32'h10, 0, 1, 32'h1000_000C));
    vecs.push_back(mk(0, 0, 0, 32'h0,  1, 32'hBAD0_BAD0, 1, 32'h10, 0, 0, 32'h1000_000C));
    vecs.push_back(mk(0, 1, 0, 32'h0,  1, 32'h2000_0200, 1, 32'h200, 0, 0, 32'h1000_000C));
    vecs.push_back(mk(0, 1, 1, 32'h40, 1, 32'h0,         0, 32'h200, 0, 1, 32'h2000_0200));
    vecs.push_back(mk(0, 0, 1, 32'hFFFF_FFF8, 1, 32'h1111_1111,
                                                         1, 32'h40, 0, 1, 32'h2000_0200));
    vecs.push_back(mk(0, 0, 0, 32'h0,  1, 32'h2000_FFF8, 1, 32'hFFFF_FFF8, 1, 0, 32'h2000_0200));
    vecs.push_back(mk(0, 0, 0, 32'h0,  1, 32'h2000_FFFC, 1, 32'hFFFF_FFFC, 1, 0, 32'h2000_FFF8));
    vecs.push_back(mk(0, 0, 1, 32'h300, 0, 32'h0,        1, 32'h0, 0, 1, 32'h2000_FFFC));
    vecs.push_back(mk(1, 0, 0, 32'h0,  0, 32'h0,         1, 32'h0, 0, 0, 32'h2000_FFFC));
    vecs.push_back(mk(0, 0, 0, 32'h0,  1, 32'h3333_3333, 0, 32'h0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,  1, 32'h4444_4444, 1, 32'h0, 1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,  0, 32'h0,         1, 32'h4, 0, 0, 32'h4444_4444));
    vecs.push_back(mk(0, 0, 1, 32'h500, 0, 32'h0,        1, 32'h4, 0, 1, 32'h4444_4444));
    vecs.push_back(mk(0, 0, 1, 32'h600, 1, 32'h5555_5555, 1, 32'h4, 0, 1, 32'h4444_4444));
    vecs.push_back(mk(0, 0, 0, 32'h0,  0, 32'h0,         1, 32'h600, 0, 0, 32'h4444_4444));

    reset = 1'b1; stall_d = 1'b0; redirect_e = 1'b0; redirect_pc_e = 32'h0;
    imem_ready = 1'b0; imem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[i]) apply(i, vecs[i]);

    // Back-to-back sequential fetches from 0x600 with memory always ready.
    prev = 32'h4444_4444;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] word;
      word = 32'hC000_0000 + 32'(i * 3 + 7);
      apply(100 + i, mk(0, 0, 0, 32'h0, 1, word, 1, 32'h600 + 32'(4 * i), 1, 0, prev));
      prev = word;
    end

    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish, want finish before limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 The module SHALL provide parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The module SHALL provide parameter PC_STEP, default 32'd4, meaning the sequential PC increment.
REQ-003 The module SHALL have one clock; reset is synchronous and active-high.
REQ-004 The module SHALL have ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall_d  in  1  decode stage cannot accept a new instruction
- redirect_e  in  1  taken branch/jump resolved in execute
- redirect_pc_e  in  32  redirect target
- imem_ready  in  1  instruction memory returns data this cycle
- imem_rdata  in  32  instruction word, valid when imem_ready=1
- imem_req  out  1  instruction memory request
- imem_addr  out  32  request address
- fetch_en  out  1  enable to the fetch/decode stage register
- pc_next_f  out  32  PC handed to the fetch/decode stage register
- instr_f  out  32  captured instruction word
- flush_d  out  1  invalidate the decode stage this cycle

Function
REQ-005 The FSM SHALL have states BOOT, REQ, HOLD and KILL.
REQ-006 Register pc_f SHALL hold the current fetch PC; imem_addr SHALL equal pc_f.
REQ-007 imem_req SHALL be 1 exactly in REQ and KILL; imem_addr SHALL stay stable while imem_req=1 and imem_ready=0.
REQ-008 BOOT SHALL go to REQ unconditionally after one cycle.
REQ-009 In REQ with imem_ready=1, redirect_e=0, stall_d=0: instr_f SHALL load imem_rdata; fetch_en=1 and pc_next_f=pc_f in the same cycle; pc_f SHALL become pc_f+PC_STEP (mod 2^32); the FSM SHALL stay in REQ.
REQ-010 In REQ with imem_ready=1, redirect_e=0, stall_d=1: instr_f SHALL load imem_rdata; fetch_en=0; pc_f SHALL be unchanged; next state SHALL be HOLD.
REQ-011 In HOLD with redirect_e=0: imem_req=0. If stall_d=0, fetch_en=1, pc_next_f=pc_f, pc_f SHALL become pc_f+PC_STEP and next state SHALL be REQ. Otherwise the FSM SHALL stay in HOLD.
REQ-012 redirect_e SHALL have priority over stall_d and imem_ready; flush_d SHALL equal 1 in every cycle in which redirect_e=1 is accepted (any state except BOOT), and fetch_en SHALL be 0 in that cycle.
REQ-013 In REQ with redirect_e=1 and imem_ready=1, or in HOLD with redirect_e=1: returned or held data SHALL be discarded, pc_f SHALL load redirect_pc_e, and next state SHALL be REQ.
REQ-014 In REQ with redirect_e=1 and imem_ready=0: target register tgt SHALL load redirect_pc_e, pc_f SHALL be unchanged, and next state SHALL be KILL.
REQ-015 In KILL: a new redirect_e=1 SHALL overwrite tgt (latest wins). On imem_ready=1, data SHALL be discarded, pc_f SHALL load tgt (or redirect_pc_e if redirect_e=1 in the same cycle), and next state SHALL be REQ. fetch_en SHALL be 0 throughout KILL.
REQ-016 pc_next_f SHALL equal pc_f in all cycles; outputs SHALL be meaningful only when fetch_en=1.
REQ-017 pc_f arithmetic SHALL be 32-bit unsigned and wrap 32'hFFFF_FFFC+4 to 32'h0000_0000.
REQ-018 redirect_e in BOOT SHALL be ignored, with flush_d=0.

Reset
REQ-019 On reset=1 at a rising clk edge, the state SHALL become BOOT, pc_f=RESET_PC, tgt=0 and instr_f=0. imem_req, fetch_en and flush_d SHALL be 0 during BOOT.
REQ-020 Reset SHALL abort any outstanding request or KILL sequence without waiting for imem_ready. Data returned after reset SHALL be ignored until the next request.

Verification
REQ-021 Reset, imem_ready always 1, stall_d=0 -> imem_req rises 1 cycle after reset; fetch_en=1 every cycle with pc_next_f=0,4,8,12; instr_f tracks imem_rdata.
REQ-022 imem_ready low 3 cycles at addr 8 -> imem_addr stays 8 with imem_req=1 and fetch_en=0; on ready, fetch_en=1 with pc_next_f=8, then addr 12.
REQ-023 stall_d=1 for 2 cycles when word at 4 returns -> HOLD; instr_f is held and imem_req=0; when stall_d drops, fetch_en=1 with pc_next_f=4, then imem_addr=8.
REQ-024 redirect_e=1, redirect_pc_e=0x100 while the request at 0x10 is pending (ready=0) -> flush_d=1 for 1 cycle; KILL holds addr 0x10; on ready, the data is dropped (fetch_en=0) and the next imem_addr=0x100.
REQ-025 redirect_e=1 to 0x40 with stall_d=1 in HOLD -> flush_d=1, fetch_en=0, next imem_addr=0x40; also check that pc_f=32'hFFFF_FFFC sequential fetch wraps to 0.
REQ-026 reset=1 asserted in KILL -> next cycle state is BOOT, pc_f=RESET_PC, and all outputs are 0.
